// File: rtl/synth_pkg.sv
// Shared synth types and constants: phase width, default voice count, scheduler states.
`default_nettype none

package synth_pkg;

  localparam int PHASE_W      = 19;
  localparam int N_VOICES_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : synth_pkg

`default_nettype wire

// File: rtl/NineteenBitFullAdder.sv
// Shared PHASE_W-bit full adder with carry-in and carry-out.
`default_nettype none

module NineteenBitFullAdder
  import synth_pkg::*;
(
  input  logic [PHASE_W-1:0] a_i,
  input  logic [PHASE_W-1:0] b_i,
  input  logic               c_i,
  output logic [PHASE_W-1:0] sum_o,
  output logic               c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{PHASE_W{1'b0}}, c_i};

endmodule : NineteenBitFullAdder

`default_nettype wire

// File: rtl/voice_phase_scheduler.sv
// Steps every voice's phase accumulator once per sample tick through one shared adder,
// streaming each new phase with its voice index.
`default_nettype none

module voice_phase_scheduler
  import synth_pkg::*;
#(
  parameter  int N_VOICES = N_VOICES_DEF,
  localparam int IDX_W    = $clog2(N_VOICES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick_i,
  input  logic                inc_we_i,
  input  logic [IDX_W-1:0]    inc_addr_i,
  input  logic [PHASE_W-1:0]  inc_data_i,
  input  logic                sync_we_i,
  input  logic [IDX_W-1:0]    sync_addr_i,
  input  logic [N_VOICES-1:0] voice_en_i,
  input  logic                overrun_clr_i,
  output logic                busy_o,
  output logic                phase_valid_o,
  output logic [IDX_W-1:0]    phase_voice_o,
  output logic [PHASE_W-1:0]  phase_out_o,
  output logic                phase_wrap_o,
  output logic                frame_done_o,
  output logic                overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PHASE_W-1:0] phase_q [N_VOICES];
  logic [PHASE_W-1:0] inc_q   [N_VOICES];

  logic               phase_valid_q;
  logic [IDX_W-1:0]   phase_voice_q;
  logic [PHASE_W-1:0] phase_out_q;
  logic               phase_wrap_q;
  logic               frame_done_q;
  logic               overrun_q;

  logic [PHASE_W-1:0] sum;
  logic               carry;
  logic               sync_hit;
  logic [PHASE_W-1:0] upd_phase_d;
  logic               upd_wrap_d;

  NineteenBitFullAdder u_adder (
    .a_i   (phase_q[idx_q]),
    .b_i   (inc_q[idx_q]),
    .c_i   (1'b0),
    .sum_o (sum),
    .c_o   (carry)
  );

  // Hard sync beats the accumulate; a disabled voice re-emits its held phase.
  always_comb begin
    sync_hit    = sync_we_i && (sync_addr_i == idx_q);
    upd_phase_d = phase_q[idx_q];
    upd_wrap_d  = 1'b0;
    if (sync_hit) begin
      upd_phase_d = '0;
    end else if (voice_en_i[idx_q]) begin
      upd_phase_d = sum;
      upd_wrap_d  = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) phase_q[v] <= '0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (sync_we_i && (sync_addr_i == IDX_W'(v))) begin
          phase_q[v] <= '0;
        end else if ((state_q == RUN) && (idx_q == IDX_W'(v))) begin
          phase_q[v] <= upd_phase_d;
        end
      end
    end
  end

  // The adder reads the pre-write increment, so a same-edge write lands next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) inc_q[v] <= '0;
    end else if (inc_we_i) begin
      inc_q[inc_addr_i] <= inc_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      phase_valid_q <= 1'b0;
      phase_voice_q <= '0;
      phase_out_q   <= '0;
      phase_wrap_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      phase_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (overrun_clr_i) overrun_q <= 1'b0;
      if ((state_q == RUN) && sample_tick_i) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_tick_i) begin
            state_q <= RUN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          phase_valid_q <= 1'b1;
          phase_voice_q <= idx_q;
          phase_out_q   <= upd_phase_d;
          phase_wrap_q  <= upd_wrap_d;
          if (idx_q == LAST_IDX) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
            idx_q        <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o        = (state_q == RUN);
  assign phase_valid_o = phase_valid_q;
  assign phase_voice_o = phase_voice_q;
  assign phase_out_o   = phase_out_q;
  assign phase_wrap_o  = phase_wrap_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;

endmodule : voice_phase_scheduler

`default_nettype wire
